// File: rtl/layer_compositor.sv
// layer_compositor
//   Three-stage pixel compositor: merges NUM_LAYERS sprite palette indices with
//   a tiled background map, resolves priority, looks up the palette and drives
//   registered VGA RGB. RGB at cycle t+3 reflects the inputs sampled at cycle t.
//   The optional brightness fade is built only when COMPOSITOR_FADE_EN is defined.
//   Without it, Bright is a constant 16, FadeBusy is 0, and the fade inputs are ignored.
//
// Ports
//   Clk        pixel clock
//   Reset      asynchronous, active-high
//   Blank      active-low blanking, aligned with DrawX/DrawY
//   FrameTick  one-cycle pulse at frame start (fade step)
//   Map        map select, sampled in stage 1
//   DrawX/Y    pixel column / row
//   LayerPix   layer i palette index at [i*IDX_W +: IDX_W]; 0 = transparent
//   PrioSwap   bit i swaps the priority of layers i+1 and i+2
//   FadeReq    start a fade (pulse); FadeDir 1 = to black, 0 = to full
//   FadeBusy   fade in progress
//   Red/Green/Blue  registered colour outputs
//
// Map ROM content: idx = (tile*37 + py*5 + px*3) mod 2**IDX_W.
// Palette: R/G are the index (G inverted) replicated up to 8 bits; B = R ^ 8'hA5.
// Requires NUM_LAYERS >= 3 and IDX_W >= 6.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 6,
    parameter int TILE_LOG2  = 4,
    parameter int TILES_X    = 40,
    parameter int TILES_Y    = 30,
    parameter int MAP_W      = 2,
    parameter int FG_IDX_MIN = 48
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Blank,
    input  logic                        FrameTick,
    input  logic [MAP_W-1:0]            Map,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic [NUM_LAYERS*IDX_W-1:0] LayerPix,
    input  logic [NUM_LAYERS-2:0]       PrioSwap,
    input  logic                        FadeReq,
    input  logic                        FadeDir,
    output logic                        FadeBusy,
    output logic [7:0]                  Red,
    output logic [7:0]                  Green,
    output logic [7:0]                  Blue
);
    localparam int TILE_W = $clog2((2**MAP_W) * TILES_X * TILES_Y);
    localparam int NL     = NUM_LAYERS - 1;   // layers below the text layer

    function automatic logic [IDX_W-1:0] map_rom(input logic [TILE_W-1:0] t,
                                                 input logic [TILE_LOG2-1:0] x,
                                                 input logic [TILE_LOG2-1:0] y);
        return IDX_W'(t) * IDX_W'(37) + IDX_W'(y) * IDX_W'(5) + IDX_W'(x) * IDX_W'(3);
    endfunction

    function automatic logic [23:0] palette_rom(input logic [IDX_W-1:0] idx);
        logic [7:0] r;
        logic [7:0] g;
        r = 8'({idx, idx} >> (2 * IDX_W - 8));
        g = 8'({~idx, ~idx} >> (2 * IDX_W - 8));
        return {r, g, r ^ 8'hA5};
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] b);
        return 8'((13'(c) * 13'(b)) >> 4);
    endfunction

    // ---------------- stage 1: capture + tile address ----------------
    logic [NUM_LAYERS-1:0][IDX_W-1:0] lp_d, lp_q;
    logic [NL-2:0]                    swap_d, swap_q;
    logic                             blank1_d, blank1_q;
    logic [TILE_LOG2-1:0]             px_d, px_q, py_d, py_q;
    logic [TILE_W-1:0]                tile_d, tile_q;
    logic                             oor_d, oor_q;

    // The top PrioSwap bit would pair the last layer with a non-existent one.
    logic unused_swap_top;
    assign unused_swap_top = PrioSwap[NUM_LAYERS-2];

    always_comb begin
        lp_d     = LayerPix;
        swap_d   = PrioSwap[NL-2:0];
        blank1_d = Blank;
        px_d     = DrawX[TILE_LOG2-1:0];
        py_d     = DrawY[TILE_LOG2-1:0];
        tile_d   = TILE_W'(Map) * TILE_W'(TILES_X * TILES_Y)
                 + TILE_W'(DrawY[9:TILE_LOG2]) * TILE_W'(TILES_X)
                 + TILE_W'(DrawX[9:TILE_LOG2]);
        oor_d    = (DrawX >= 10'(TILES_X << TILE_LOG2));
    end

    // ---------------- stage 2: map read + priority ----------------
    logic [IDX_W-1:0]         map_idx, idx_d, idx_q, tmp;
    logic [NL-1:0][IDX_W-1:0] ord;
    logic                     prev;
    logic                     blank2_d, blank2_q;

    always_comb begin
        map_idx = oor_q ? '0 : map_rom(tile_q, px_q, py_q);
        for (int i = 0; i < NL; i++) ord[i] = lp_q[i+1];
        // Adjacent swaps applied from bit 0 upward; a swap is skipped when the
        // previous one already moved its upper layer, so nothing moves twice.
        tmp  = '0;
        prev = 1'b0;
        for (int i = 0; i < NL - 1; i++) begin
            if (swap_q[i] && !prev) begin
                tmp      = ord[i];
                ord[i]   = ord[i+1];
                ord[i+1] = tmp;
                prev     = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        // Built lowest priority first so later assignments win.
        idx_d = map_idx;
        for (int i = NL - 1; i >= 0; i--)
            if (ord[i] != '0) idx_d = ord[i];
        if (map_idx >= IDX_W'(FG_IDX_MIN)) idx_d = map_idx;
        if (lp_q[0] != '0) idx_d = lp_q[0];
        blank2_d = blank1_q;
    end

    // ---------------- stage 3: palette + brightness ----------------
    logic [4:0]  bright;
    logic [23:0] pal;
    logic [7:0]  red_d, red_q, green_d, green_q, blue_d, blue_q;

    always_comb begin
        pal     = palette_rom(idx_q);
        red_d   = blank2_q ? scale(pal[23:16], bright) : 8'd0;
        green_d = blank2_q ? scale(pal[15:8],  bright) : 8'd0;
        blue_d  = blank2_q ? scale(pal[7:0],   bright) : 8'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lp_q     <= '0;
            swap_q   <= '0;
            blank1_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            tile_q   <= '0;
            oor_q    <= 1'b0;
            idx_q    <= '0;
            blank2_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            lp_q     <= lp_d;
            swap_q   <= swap_d;
            blank1_q <= blank1_d;
            px_q     <= px_d;
            py_q     <= py_d;
            tile_q   <= tile_d;
            oor_q    <= oor_d;
            idx_q    <= idx_d;
            blank2_q <= blank2_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign Red   = red_q;
    assign Green = green_q;
    assign Blue  = blue_q;

    // ---------------- fade control ----------------
`ifdef COMPOSITOR_FADE_EN
    typedef enum logic {F_IDLE, F_STEP} fade_state_e;

    fade_state_e state_d, state_q;
    logic        dir_d, dir_q;
    logic [4:0]  bright_d, bright_q, bright_nx;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        bright_d  = bright_q;
        bright_nx = dir_q ? ((bright_q == 5'd0)  ? 5'd0  : bright_q - 5'd1)
                          : ((bright_q >= 5'd16) ? 5'd16 : bright_q + 5'd1);
        case (state_q)
            F_IDLE: begin
                // A tick in the same cycle as the request is not a step.
                if (FadeReq) begin
                    dir_d   = FadeDir;
                    state_d = F_STEP;
                end
            end
            F_STEP: begin
                if (FrameTick) begin
                    bright_d = bright_nx;
                    if (bright_nx == (dir_q ? 5'd0 : 5'd16)) state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= F_IDLE;
            dir_q    <= 1'b0;
            bright_q <= 5'd16;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            bright_q <= bright_d;
        end
    end

    assign bright   = bright_q;
    assign FadeBusy = (state_q == F_STEP);
`else
    logic unused_fade;
    assign unused_fade = ^{FadeReq, FadeDir, FrameTick};
    assign bright      = 5'd16;
    assign FadeBusy    = 1'b0;
`endif

endmodule
